ysyx_22041752_wb_queue: RTL and testbench

Parametrised writeback stage that replaces the single-register WS latch with a DEPTH-entry in-order writeback queue between the MEM stage and the register-file write port. Each entry retires only when the register file grants its write port (`rf_ready`), so the port can be shared with other writers (CSR unit, late load returns) without stalling MEM until the queue fills. Two combinational lookup channels give ID-stage forwarding of the newest pending write to a queried register.

---
 rtl/ysyx_22041752_wb_queue.sv | 175 +++++++++++++++++
 tb/tb_ysyx_22041752_wb_queue.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041752_wb_queue.sv
// In-order writeback queue between MEM and the register-file write port.
// Entries retire only on rf_ready; two lookup channels forward the youngest pending write.
module ysyx_22041752_wb_queue #(
  parameter int RF_ADDR_WD = 5,
  parameter int RF_DATA_WD = 64,
  parameter int PC_WD      = 64,
  parameter int DEPTH      = 4,
  parameter int CNT_WD     = $clog2(DEPTH) + 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 ms_to_ws_valid,
  input  logic [RF_ADDR_WD+RF_DATA_WD+PC_WD:0] ms_to_ws_bus,
  output logic                                 ws_allowin,
  input  logic                                 rf_ready,
  output logic [RF_ADDR_WD+RF_DATA_WD:0]       ws_to_rf_bus,
  output logic                                 ws_retire_valid,
  output logic [PC_WD-1:0]                     ws_retire_pc,
  output logic [CNT_WD-1:0]                    ws_count,
  input  logic [RF_ADDR_WD-1:0]                fwd_raddr1,
  input  logic [RF_ADDR_WD-1:0]                fwd_raddr2,
  output logic                                 fwd_hit1,
  output logic                                 fwd_hit2,
  output logic [RF_DATA_WD-1:0]                fwd_data1,
  output logic [RF_DATA_WD-1:0]                fwd_data2
);

  localparam int BUS_WD = 1 + RF_ADDR_WD + RF_DATA_WD + PC_WD;
  localparam int PTR_WD = $clog2(DEPTH);

  logic                  valid_q [DEPTH];
  logic                  valid_d [DEPTH];
  logic                  we_q    [DEPTH];
  logic                  we_d    [DEPTH];
  logic [RF_ADDR_WD-1:0] rd_q    [DEPTH];
  logic [RF_ADDR_WD-1:0] rd_d    [DEPTH];
  logic [RF_DATA_WD-1:0] wdata_q [DEPTH];
  logic [RF_DATA_WD-1:0] wdata_d [DEPTH];
  logic [PC_WD-1:0]      pc_q    [DEPTH];
  logic [PC_WD-1:0]      pc_d    [DEPTH];

  logic [PTR_WD-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CNT_WD-1:0] cnt_q, cnt_d;

  logic                  in_we;
  logic [RF_ADDR_WD-1:0] in_rd;
  logic [RF_DATA_WD-1:0] in_wdata;
  logic [PC_WD-1:0]      in_pc;
  logic                  non_empty, push, pop;

  assign in_we    = ms_to_ws_bus[BUS_WD-1];
  assign in_rd    = ms_to_ws_bus[BUS_WD-2 -: RF_ADDR_WD];
  assign in_wdata = ms_to_ws_bus[PC_WD +: RF_DATA_WD];
  assign in_pc    = ms_to_ws_bus[PC_WD-1:0];

  // allowin looks only at registered occupancy so MEM never waits on rf_ready
  assign ws_allowin = (cnt_q != CNT_WD'(DEPTH));
  assign non_empty  = (cnt_q != '0);
  assign push       = ms_to_ws_valid && ws_allowin;
  assign pop        = non_empty && rf_ready;
  assign ws_count   = cnt_q;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      we_d[i]    = we_q[i];
      rd_d[i]    = rd_q[i];
      wdata_d[i] = wdata_q[i];
      pc_d[i]    = pc_q[i];
    end
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) begin
      valid_d[wp_q] = 1'b1;
      we_d[wp_q]    = in_we;
      rd_d[wp_q]    = in_rd;
      wdata_d[wp_q] = in_wdata;
      pc_d[wp_q]    = in_pc;
      wp_d          = wp_q + PTR_WD'(1);
    end
    if (pop) begin
      valid_d[rp_q] = 1'b0;
      rp_d          = rp_q + PTR_WD'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_WD'(1);
      2'b01:   cnt_d = cnt_q - CNT_WD'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        we_q[i]    <= 1'b0;
        rd_q[i]    <= '0;
        wdata_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= valid_d[i];
        we_q[i]    <= we_d[i];
        rd_q[i]    <= rd_d[i];
        wdata_q[i] <= wdata_d[i];
        pc_q[i]    <= pc_d[i];
      end
    end
  end

  logic                  head_we;
  logic [RF_ADDR_WD-1:0] head_rd;
  logic [RF_DATA_WD-1:0] head_wdata;
  logic [PC_WD-1:0]      head_pc;
  logic                  rf_we;

  always_comb begin
    head_we    = 1'b0;
    head_rd    = '0;
    head_wdata = '0;
    head_pc    = '0;
    if (non_empty) begin
      head_we    = we_q[rp_q];
      head_rd    = rd_q[rp_q];
      head_wdata = wdata_q[rp_q];
      head_pc    = pc_q[rp_q];
    end
  end

  // rd=0 entries still retire and consume the grant, they just never write
  assign rf_we           = pop && head_we && (head_rd != '0);
  assign ws_to_rf_bus    = {rf_we, head_rd, head_wdata};
  assign ws_retire_valid = pop;
  assign ws_retire_pc    = head_pc;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic [RF_ADDR_WD-1:0] addr;
      logic                  hit;
      logic [RF_DATA_WD-1:0] data;
      logic [PTR_WD-1:0]     idx;

      assign addr = (gi == 0) ? fwd_raddr1 : fwd_raddr2;

      // walk oldest to youngest so the last match seen is the newest write
      always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
          idx = rp_q + PTR_WD'(i);
          if (valid_q[idx] && we_q[idx] && (rd_q[idx] == addr) && (rd_q[idx] != '0)) begin
            hit  = 1'b1;
            data = wdata_q[idx];
          end
        end
      end
    end
  endgenerate

  assign fwd_hit1  = g_fwd[0].hit;
  assign fwd_data1 = g_fwd[0].data;
  assign fwd_hit2  = g_fwd[1].hit;
  assign fwd_data2 = g_fwd[1].data;

endmodule

// File: tb/tb_ysyx_22041752_wb_queue.sv
// Bench for the writeback queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_ysyx_22041752_wb_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic [63:0] pc;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ms_to_ws_valid;
  ent_t        ms_to_ws_bus;
  logic        ws_allowin;
  logic        rf_ready;
  logic [69:0] ws_to_rf_bus;
  logic        ws_retire_valid;
  logic [63:0] ws_retire_pc;
  logic [2:0]  ws_count;
  logic [4:0]  fwd_raddr1, fwd_raddr2;
  logic        fwd_hit1, fwd_hit2;
  logic [63:0] fwd_data1, fwd_data2;

  ysyx_22041752_wb_queue dut (
    .clk(clk), .reset(reset),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ws_allowin(ws_allowin), .rf_ready(rf_ready),
    .ws_to_rf_bus(ws_to_rf_bus), .ws_retire_valid(ws_retire_valid),
    .ws_retire_pc(ws_retire_pc), .ws_count(ws_count),
    .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: a plain FIFO of entries, oldest at index 0
  ent_t        q[$];
  logic        exp_allowin, exp_push, exp_pop;
  logic [69:0] exp_bus;
  logic [63:0] exp_rpc;
  logic        exp_hit1, exp_hit2;
  logic [63:0] exp_data1, exp_data2;

  function automatic ent_t mk(logic we, logic [4:0] rd, logic [63:0] d, logic [63:0] pc);
    return {we, rd, d, pc};
  endfunction

  task automatic model_eval();
    ent_t head;
    bit   f1, f2;
    head        = (q.size() != 0) ? q[0] : '0;
    exp_allowin = (q.size() != DEPTH);
    exp_push    = ms_to_ws_valid && exp_allowin;
    exp_pop     = (q.size() != 0) && rf_ready;
    exp_bus     = {exp_pop && head.we && (head.rd != 0), head.rd, head.wdata};
    exp_rpc     = head.pc;
    exp_hit1 = 0; exp_data1 = '0; exp_hit2 = 0; exp_data2 = '0;
    f1 = 0; f2 = 0;
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (!f1 && q[k].we && q[k].rd != 0 && q[k].rd == fwd_raddr1) begin
        f1 = 1; exp_hit1 = 1; exp_data1 = q[k].wdata;
      end
      if (!f2 && q[k].we && q[k].rd != 0 && q[k].rd == fwd_raddr2) begin
        f2 = 1; exp_hit2 = 1; exp_data2 = q[k].wdata;
      end
    end
  endtask

  task automatic step(input logic v, input ent_t e, input logic r, input logic [4:0] a1, input logic [4:0] a2);
    @(negedge clk);
    ms_to_ws_valid = v;
    ms_to_ws_bus   = e;
    rf_ready       = r;
    fwd_raddr1     = a1;
    fwd_raddr2     = a2;
    #1;
    model_eval();
  endtask

  task automatic commit();
    @(posedge clk);
    if (exp_pop) q.delete(0);
    if (exp_push) q.push_back(ms_to_ws_bus);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      step(0, '0, 1, 0, 0);
      commit();
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (ws_allowin !== 1'b1) begin bad++; $display("FAIL reset_allowin got=%0b want=1", ws_allowin); end
    total++; if (ws_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", ws_count); end
    total++; if (ws_to_rf_bus !== 70'd0) begin bad++; $display("FAIL reset_rfbus got=%h want=0", ws_to_rf_bus); end
    total++; if (ws_retire_valid !== 1'b0 || ws_retire_pc !== 64'd0) begin
      bad++; $display("FAIL reset_retire got=%0b/%h want=0/0", ws_retire_valid, ws_retire_pc); end
    total++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0 || fwd_data1 !== 64'd0 || fwd_data2 !== 64'd0) begin
      bad++; $display("FAIL reset_fwd got=%0b%0b want=00", fwd_hit1, fwd_hit2); end
    $display("reset: allowin=%0b count=%0d", ws_allowin, ws_count);
  endtask

  task automatic test_basic();
    step(1, mk(1, 5, 64'hAA, 64'h8000_0000), 1, 5, 0);
    total++; if (ws_retire_valid !== 1'b0) begin bad++; $display("FAIL basic_no_early_retire got=%0b want=0", ws_retire_valid); end
    commit();
    step(0, '0, 1, 5, 0);
    total++; if (ws_to_rf_bus !== {1'b1, 5'd5, 64'hAA}) begin
      bad++; $display("FAIL basic_rfbus got=%h want=%h", ws_to_rf_bus, {1'b1, 5'd5, 64'hAA}); end
    total++; if (ws_retire_valid !== 1'b1 || ws_retire_pc !== 64'h8000_0000) begin
      bad++; $display("FAIL basic_retire got=%0b/%h want=1/80000000", ws_retire_valid, ws_retire_pc); end
    total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 64'hAA) begin
      bad++; $display("FAIL basic_fwd_retiring got=%0b/%h want=1/aa", fwd_hit1, fwd_data1); end
    commit();
    step(0, '0, 1, 0, 0);
    total++; if (ws_count !== 3'd0) begin bad++; $display("FAIL basic_count got=%0d want=0", ws_count); end
    commit();
    $display("basic: push rd=5 retired pc=80000000");
  endtask

  task automatic test_full();
    ent_t e[5];
    for (int i = 0; i < 5; i++) e[i] = mk(1, 5'(i + 1), 64'(i + 16), 64'(256 * i));
    for (int i = 0; i < 5; i++) begin
      step(1, e[i], 0, 0, 0);
      total++; if (ws_count !== 3'(i < 4 ? i : 4)) begin bad++; $display("FAIL full_count[%0d] got=%0d want=%0d", i, ws_count, (i < 4 ? i : 4)); end
      total++; if (ws_allowin !== (i < 4)) begin bad++; $display("FAIL full_allowin[%0d] got=%0b want=%0b", i, ws_allowin, (i < 4)); end
      commit();
    end
    step(1, e[4], 1, 0, 0);
    total++; if (ws_allowin !== 1'b0 || ws_retire_pc !== 64'd0 || ws_retire_valid !== 1'b1) begin
      bad++; $display("FAIL full_first_pop allowin=%0b pc=%h want allowin=0 pc=0", ws_allowin, ws_retire_pc); end
    commit();
    step(1, e[4], 1, 0, 0);
    total++; if (ws_allowin !== 1'b1 || ws_retire_pc !== 64'd256) begin
      bad++; $display("FAIL full_reopen allowin=%0b pc=%h want allowin=1 pc=100", ws_allowin, ws_retire_pc); end
    commit();
    for (int j = 2; j < 5; j++) begin
      step(0, '0, 1, 0, 0);
      total++; if (ws_retire_valid !== 1'b1 || ws_retire_pc !== 64'(256 * j)) begin
        bad++; $display("FAIL full_order[%0d] got=%0b/%h want=1/%h", j, ws_retire_valid, ws_retire_pc, 64'(256 * j)); end
      commit();
    end
    step(0, '0, 1, 0, 0);
    total++; if (ws_count !== 3'd0) begin bad++; $display("FAIL full_drained got=%0d want=0", ws_count); end
    commit();
    $display("full: 5 pushes, 5 in-order retires");
  endtask

  task automatic test_forward();
    step(1, mk(1, 3, 64'h11, 64'h10), 0, 0, 0); commit();
    step(1, mk(1, 3, 64'h22, 64'h14), 0, 0, 0); commit();
    step(0, '0, 0, 3, 4);
    total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 64'h22) begin
      bad++; $display("FAIL fwd_newest got=%0b/%h want=1/22", fwd_hit1, fwd_data1); end
    total++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 64'd0) begin
      bad++; $display("FAIL fwd_miss got=%0b/%h want=0/0", fwd_hit2, fwd_data2); end
    commit();
    drain();
    $display("forward: rd3 -> %h, rd4 hit=%0b", fwd_data1, fwd_hit2);
  endtask

  task automatic test_rd0_we0();
    step(1, mk(1, 0, 64'hFF, 64'h20), 0, 0, 7); commit();
    step(1, mk(0, 7, 64'h77, 64'h24), 0, 0, 7); commit();
    step(0, '0, 0, 0, 7);
    total++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0) begin
      bad++; $display("FAIL rd0we0_fwd got=%0b%0b want=00", fwd_hit1, fwd_hit2); end
    commit();
    for (int i = 0; i < 2; i++) begin
      step(0, '0, 1, 0, 7);
      total++; if (ws_retire_valid !== 1'b1 || ws_to_rf_bus[69] !== 1'b0) begin
        bad++; $display("FAIL rd0we0_retire[%0d] valid=%0b rf_we=%0b want 1/0", i, ws_retire_valid, ws_to_rf_bus[69]); end
      commit();
    end
    $display("rd0/we0: both retired without write");
  endtask

  task automatic test_back_to_back();
    logic [63:0] pcs[$];
    for (int i = 0; i < 10; i++) begin
      step(1, mk(1, 5'(i + 1), 64'(i), 64'(4 * i + 64'h1000)), 1, 0, 0);
      total++; if (ws_count > 3'd1 || ws_allowin !== 1'b1) begin
        bad++; $display("FAIL b2b_occupancy[%0d] count=%0d allowin=%0b want <=1/1", i, ws_count, ws_allowin); end
      if (ws_retire_valid) begin
        total++; if (pcs.size() == 0 || ws_retire_pc !== pcs[0]) begin
          bad++; $display("FAIL b2b_order[%0d] got=%h", i, ws_retire_pc); end
        if (pcs.size() != 0) pcs.delete(0);
      end
      pcs.push_back(64'(4 * i + 64'h1000));
      commit();
    end
    step(0, '0, 1, 0, 0);
    total++; if (ws_retire_pc !== pcs[0]) begin bad++; $display("FAIL b2b_last got=%h want=%h", ws_retire_pc, pcs[0]); end
    commit();
    $display("back_to_back: 10 entries at one per cycle");
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 9) < 7,
           mk($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom}),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      total++;
      if (ws_allowin !== exp_allowin || ws_count !== 3'(q.size()) || ws_to_rf_bus !== exp_bus ||
          ws_retire_valid !== exp_pop || ws_retire_pc !== exp_rpc || fwd_hit1 !== exp_hit1 ||
          fwd_data1 !== exp_data1 || fwd_hit2 !== exp_hit2 || fwd_data2 !== exp_data2) begin
        bad++; errs++;
        $display("FAIL random[%0d] got cnt=%0d bus=%h rv=%0b pc=%h h1=%0b d1=%h h2=%0b d2=%h want cnt=%0d bus=%h rv=%0b pc=%h h1=%0b d1=%h h2=%0b d2=%h",
                 i, ws_count, ws_to_rf_bus, ws_retire_valid, ws_retire_pc, fwd_hit1, fwd_data1, fwd_hit2, fwd_data2,
                 q.size(), exp_bus, exp_pop, exp_rpc, exp_hit1, exp_data1, exp_hit2, exp_data2);
      end
      commit();
    end
    drain();
    $display("random: 300 cycles, %0d mismatching cycles", errs);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      step(1, mk(1, 2, 64'(i + 100), 64'(i)), 0, 2, 0);
      commit();
    end
    @(negedge clk);
    ms_to_ws_valid = 0;
    rf_ready       = 1;
    fwd_raddr1     = 2;
    #2 reset = 1;
    #1;
    total++; if (ws_count !== 3'd0 || ws_allowin !== 1'b1) begin
      bad++; $display("FAIL midreset_state count=%0d allowin=%0b want 0/1", ws_count, ws_allowin); end
    total++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0 || ws_to_rf_bus[69] !== 1'b0) begin
      bad++; $display("FAIL midreset_outputs hit=%0b%0b rf_we=%0b want 00/0", fwd_hit1, fwd_hit2, ws_to_rf_bus[69]); end
    q.delete();
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, '0, 1, 2, 0);
      total++; if (ws_retire_valid !== 1'b0) begin bad++; $display("FAIL midreset_no_retire[%0d] got=%0b want=0", i, ws_retire_valid); end
      commit();
    end
    $display("reset_mid: 3 pending entries discarded");
  endtask

  initial begin
    reset = 1; ms_to_ws_valid = 0; ms_to_ws_bus = '0; rf_ready = 0;
    fwd_raddr1 = 5'd3; fwd_raddr2 = 5'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 0;
    test_reset();
    test_basic();
    test_full();
    test_forward();
    test_rd0_we0();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
